// File: rtl/dual_pulse_monitor.sv
// Two-channel pulse monitor: sync, edge detect, rise counting and
// pulse-width records offered on a valid/ready stream.
module dual_pulse_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIDTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1y,
  input  logic               p2y,
  input  logic               clr,
  output logic               p1y_s,
  output logic               p2y_s,
  output logic               p1_rise,
  output logic               p1_fall,
  output logic               p2_rise,
  output logic               p2_fall,
  output logic [CNT_W-1:0]   p1_cnt,
  output logic [CNT_W-1:0]   p2_cnt,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic               rec_ch,
  output logic [WIDTH_W-1:0] rec_width,
  output logic               rec_ovf,
  output logic [1:0]         drop
);

  localparam logic [CNT_W-1:0]   CMAX = '1;
  localparam logic [CNT_W-1:0]   CONE = CNT_W'(1);
  localparam logic [WIDTH_W-1:0] WMAX = '1;
  localparam logic [WIDTH_W-1:0] WONE = WIDTH_W'(1);

  logic [1:0]         r_meta;
  logic [1:0]         r_sync;
  logic [1:0]         r_prev;
  logic [CNT_W-1:0]   r_cnt [2];
  logic [WIDTH_W-1:0] r_wid [2];
  logic [1:0]         r_wovf;
  logic [1:0]         r_hv;
  logic [WIDTH_W-1:0] r_hw [2];
  logic [1:0]         r_ho;
  logic [1:0]         r_drop;
  logic               r_prio;
  logic               r_lock;
  logic               r_lock_ch;

  logic [1:0] w_in;
  logic [1:0] w_rise;
  logic [1:0] w_fall;
  logic [1:0] w_xfer;
  logic       w_sel;

  assign w_in   = {p2y, p1y};
  assign w_rise = r_sync & ~r_prev;
  assign w_fall = ~r_sync & r_prev;

  // A stalled record keeps its channel even if the other one fills up.
  always_comb begin
    w_sel = r_hv[1];
    if (r_lock) begin
      w_sel = r_lock_ch;
    end else if (r_hv[0] && r_hv[1]) begin
      w_sel = r_prio;
    end
  end

  assign rec_valid = |r_hv;
  assign rec_ch    = w_sel;
  assign rec_width = r_hw[w_sel];
  assign rec_ovf   = r_ho[w_sel];
  assign w_xfer[0] = rec_valid & rec_ready & ~w_sel;
  assign w_xfer[1] = rec_valid & rec_ready & w_sel;

  assign p1y_s   = r_sync[0];
  assign p2y_s   = r_sync[1];
  assign p1_rise = w_rise[0];
  assign p1_fall = w_fall[0];
  assign p2_rise = w_rise[1];
  assign p2_fall = w_fall[1];
  assign p1_cnt  = r_cnt[0];
  assign p2_cnt  = r_cnt[1];
  assign drop    = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_prev    <= '0;
      r_wovf    <= '0;
      r_hv      <= '0;
      r_ho      <= '0;
      r_drop    <= '0;
      r_prio    <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_ch <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_cnt[c] <= '0;
        r_wid[c] <= '0;
        r_hw[c]  <= '0;
      end
    end else begin
      r_meta <= w_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      for (int c = 0; c < 2; c++) begin
        if (clr) begin
          r_cnt[c] <= '0;
        end else if (w_rise[c] && r_cnt[c] != CMAX) begin
          r_cnt[c] <= r_cnt[c] + CONE;
        end

        if (w_rise[c]) begin
          r_wid[c] <= WONE;
        end else if (w_fall[c]) begin
          r_wid[c]  <= '0;
          r_wovf[c] <= 1'b0;
        end else if (r_sync[c]) begin
          if (r_wid[c] == WMAX) begin
            r_wovf[c] <= 1'b1;
          end else begin
            r_wid[c] <= r_wid[c] + WONE;
          end
        end

        if (w_fall[c] && (!r_hv[c] || w_xfer[c])) begin
          r_hv[c] <= 1'b1;
          r_hw[c] <= r_wid[c];
          r_ho[c] <= r_wovf[c];
        end else if (w_xfer[c]) begin
          r_hv[c] <= 1'b0;
        end

        if (w_fall[c] && r_hv[c] && !w_xfer[c]) begin
          r_drop[c] <= 1'b1;
        end else if (clr) begin
          r_drop[c] <= 1'b0;
        end
      end
      if (|w_xfer) begin
        r_prio <= ~r_prio;
      end
      r_lock    <= rec_valid & ~rec_ready;
      r_lock_ch <= w_sel;
    end
  end

endmodule
